// File: rtl/ahb_pkg.sv
// Shared AHB-Lite type definitions: transfer types, sizes, response codes
// and the slave responder state encoding.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE   = 3'd0,
      HSIZE_HALF   = 3'd1,
      HSIZE_WORD   = 3'd2,
      HSIZE_DWORD  = 3'd3,
      HSIZE_4WORD  = 3'd4,
      HSIZE_8WORD  = 3'd5,
      HSIZE_16WORD = 3'd6,
      HSIZE_32WORD = 3'd7
   } hsize_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      SLV_IDLE = 2'd0,
      SLV_DATA = 2'd1,
      SLV_ERR1 = 2'd2,
      SLV_ERR2 = 2'd3
   } ahb_slv_state_e;

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module ahb_sram_mem #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IW    = 10
) (
   input  logic            clk,
   input  logic            we,
   input  logic [DW/8-1:0] strb,
   input  logic [IW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [IW-1:0]   raddr,
   output logic [DW-1:0]   rdata
);

   localparam int unsigned NB = DW / 8;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (strb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable OKAY wait states, two-cycle ERROR response
// for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int unsigned AHB_DW      = 32,
   parameter int unsigned AHB_AW      = 32,
   parameter int unsigned MEM_DEPTH   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hsel,
   input  logic [AHB_AW-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [AHB_DW-1:0] hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [AHB_DW-1:0] hrdata
);

   localparam int unsigned STRB_W   = AHB_DW / 8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   localparam logic [1:0] ST_IDLE = 2'(SLV_IDLE);
   localparam logic [1:0] ST_DATA = 2'(SLV_DATA);
   localparam logic [1:0] ST_ERR1 = 2'(SLV_ERR1);
   localparam logic [1:0] ST_ERR2 = 2'(SLV_ERR2);

   logic [1:0]          state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                ready_q, ready_nxt;
   logic                resp_q, resp_nxt;

   logic [IDX_W-1:0]    idx_q;
   logic [ADDR_LSB-1:0] lo_q;
   logic [2:0]          size_q;
   logic                write_q;

   logic                xfer;
   logic                addr_err;
   logic                complete;
   logic                accept;
   logic [AHB_AW-1:0]   word_idx;
   logic [ADDR_LSB-1:0] align_mask;
   logic                mem_we;
   logic [STRB_W-1:0]   mem_strb;
   logic [AHB_DW-1:0]   mem_rdata;

   // Burst type is accepted but every beat is handled independently
   logic unused_hburst;
   assign unused_hburst = ^hburst;

   // Address-phase decode: valid transfer and error classification
   always_comb begin
      xfer       = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
      word_idx   = haddr >> ADDR_LSB;
      align_mask = ADDR_LSB'((32'd1 << hsize) - 32'd1);
      addr_err   = (word_idx >= AHB_AW'(MEM_DEPTH))
                || (hsize > 3'(ADDR_LSB))
                || ((haddr[ADDR_LSB-1:0] & align_mask) != '0);
   end

   assign complete = ((state == ST_DATA) && (cnt == CNT_W'(WAIT_STATES))) || (state == ST_ERR2);
   assign accept   = xfer && ((state == ST_IDLE) || complete);

   // Next state, wait counter and the registered ready/response values
   always_comb begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      ready_nxt = 1'b1;
      resp_nxt  = HRESP_OKAY;
      if ((state == ST_DATA) && !complete) begin
         state_nxt = ST_DATA;
         cnt_nxt   = cnt + CNT_W'(1);
      end else if (state == ST_ERR1) begin
         state_nxt = ST_ERR2;
      end else if (accept) begin
         state_nxt = addr_err ? ST_ERR1 : ST_DATA;
      end
      case (state_nxt)
         ST_DATA: ready_nxt = (cnt_nxt == CNT_W'(WAIT_STATES));
         ST_ERR1: begin
            ready_nxt = 1'b0;
            resp_nxt  = HRESP_ERROR;
         end
         ST_ERR2: resp_nxt = HRESP_ERROR;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_q <= ready_nxt;
         resp_q  <= resp_nxt;
      end
   end

   // Address-phase capture for the upcoming data phase
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx_q   <= '0;
         lo_q    <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else if (accept) begin
         idx_q   <= haddr[ADDR_LSB +: IDX_W];
         lo_q    <= haddr[ADDR_LSB-1:0];
         size_q  <= hsize;
         write_q <= hwrite;
      end
   end

   // A reset on the commit edge drops the pending write
   assign mem_we   = reset_n && (state == ST_DATA) && complete && write_q;
   assign mem_strb = STRB_W'(((32'd1 << (32'd1 << size_q)) - 32'd1) << lo_q);

   ahb_sram_mem #(
      .DW    (AHB_DW),
      .DEPTH (MEM_DEPTH),
      .IW    (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .strb  (mem_strb),
      .waddr (idx_q),
      .wdata (hwdata),
      .raddr (idx_q),
      .rdata (mem_rdata)
   );

   assign hreadyout = ready_q;
   assign hresp     = resp_q;
   assign hrdata    = ((state == ST_DATA) && complete && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances with 0, 2 and 3 wait states
// share one driven bus; each instance's hready is looped back from its hreadyout.
module tb_ahb_sram_slave;

   logic        clk;
   logic        reset_n;
   logic [2:0]  sel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic [2:0]  rdy;
   logic [2:0]  rsp;
   logic [31:0] rd0, rd2, rd3;

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ahb_sram_slave #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset_n(reset_n), .hsel(sel[0]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(rdy[0]), .hreadyout(rdy[0]), .hresp(rsp[0]), .hrdata(rd0));

   ahb_sram_slave #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .reset_n(reset_n), .hsel(sel[1]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(rdy[1]), .hreadyout(rdy[1]), .hresp(rsp[1]), .hrdata(rd2));

   ahb_sram_slave #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset_n(reset_n), .hsel(sel[2]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(rdy[2]), .hreadyout(rdy[2]), .hresp(rsp[2]), .hrdata(rd3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
      haddr  = a;
      hwrite = wr;
      hsize  = sz;
      htrans = 2'd2;
   endtask

   initial begin
      reset_n = 1'b0;
      sel     = 3'b000;
      haddr   = '0;
      htrans  = 2'd0;
      hwrite  = 1'b0;
      hsize   = 3'd2;
      hburst  = 3'd0;
      hwdata  = '0;

      // Reset
      repeat (3) tick();
      chk("rst_ready", 32'(rdy), 32'h7);
      chk("rst_resp", 32'(rsp), 32'h0);
      chk("rst_rdata0", rd0, 32'h0);
      chk("rst_rdata3", rd3, 32'h0);
      reset_n = 1'b1;

      // Zero-wait word write then immediate read of 0x10
      sel = 3'b001;
      addr_phase(32'h10, 1'b1, 3'd2);
      tick();
      chk("ws0_wr_ready", 32'(rdy[0]), 32'h1);
      hwdata = 32'hDEADBEEF;
      addr_phase(32'h10, 1'b0, 3'd2);
      tick();
      chk("ws0_rd_ready", 32'(rdy[0]), 32'h1);
      chk("ws0_rd_resp", 32'(rsp[0]), 32'h0);
      chk("ws0_rd_data", rd0, 32'hDEADBEEF);
      htrans = 2'd0;
      tick();
      chk("ws0_idle_rdata", rd0, 32'h0);

      // Out-of-range write must not alias onto word 0
      addr_phase(32'h0, 1'b1, 3'd2);
      tick();
      hwdata = 32'h0BADF00D;
      addr_phase(32'h1000, 1'b1, 3'd2);
      tick();
      chk("oor_err1_ready", 32'(rdy[0]), 32'h0);
      chk("oor_err1_resp", 32'(rsp[0]), 32'h1);
      htrans = 2'd0;
      hwdata = 32'hFFFFFFFF;
      tick();
      chk("oor_err2_ready", 32'(rdy[0]), 32'h1);
      chk("oor_err2_resp", 32'(rsp[0]), 32'h1);
      addr_phase(32'h0, 1'b0, 3'd2);
      tick();
      chk("oor_follow_resp", 32'(rsp[0]), 32'h0);
      chk("oor_follow_data", rd0, 32'h0BADF00D);
      htrans = 2'd0;
      tick();

      // Misaligned word read, then oversized transfer back-to-back from ERR2
      addr_phase(32'h2, 1'b0, 3'd2);
      tick();
      chk("mis_err1_ready", 32'(rdy[0]), 32'h0);
      chk("mis_err1_resp", 32'(rsp[0]), 32'h1);
      chk("mis_err1_rdata", rd0, 32'h0);
      htrans = 2'd0;
      tick();
      chk("mis_err2_ready", 32'(rdy[0]), 32'h1);
      chk("mis_err2_rdata", rd0, 32'h0);
      addr_phase(32'h8, 1'b0, 3'd3);
      tick();
      chk("big_err1_ready", 32'(rdy[0]), 32'h0);
      chk("big_err1_resp", 32'(rsp[0]), 32'h1);
      htrans = 2'd0;
      tick();
      tick();
      chk("big_done_ready", 32'(rdy[0]), 32'h1);
      chk("big_done_resp", 32'(rsp[0]), 32'h0);

      // Two wait states: word 0x12345678 at 0x20, halfword 0xA5A5 at 0x22
      sel = 3'b010;
      addr_phase(32'h20, 1'b1, 3'd2);
      tick();
      chk("ws2_w0_ready", 32'(rdy[1]), 32'h0);
      htrans = 2'd0;
      hwdata = 32'h12345678;
      tick();
      chk("ws2_w1_ready", 32'(rdy[1]), 32'h0);
      tick();
      chk("ws2_w2_ready", 32'(rdy[1]), 32'h1);
      addr_phase(32'h22, 1'b1, 3'd1);
      tick();
      chk("ws2_h0_ready", 32'(rdy[1]), 32'h0);
      htrans = 2'd0;
      hwdata = 32'hA5A5A5A5;
      tick();
      tick();
      chk("ws2_h2_ready", 32'(rdy[1]), 32'h1);
      addr_phase(32'h20, 1'b0, 3'd2);
      tick();
      chk("ws2_r0_ready", 32'(rdy[1]), 32'h0);
      chk("ws2_r0_rdata", rd2, 32'h0);
      htrans = 2'd0;
      tick();
      tick();
      chk("ws2_r2_ready", 32'(rdy[1]), 32'h1);
      chk("ws2_r2_resp", 32'(rsp[1]), 32'h0);
      chk("ws2_half_data", rd2, 32'hA5A55678);
      tick();

      // Three wait states: reset in the second wait cycle drops the write
      sel = 3'b100;
      addr_phase(32'h40, 1'b1, 3'd2);
      tick();
      htrans = 2'd0;
      hwdata = 32'hCAFEF00D;
      tick();
      tick();
      tick();
      chk("ws3_pre_ready", 32'(rdy[2]), 32'h1);
      tick();
      addr_phase(32'h40, 1'b1, 3'd2);
      tick();
      htrans = 2'd0;
      hwdata = 32'h55555555;
      tick();
      chk("ws3_wait2_ready", 32'(rdy[2]), 32'h0);
      reset_n = 1'b0;
      tick();
      chk("ws3_rst_ready", 32'(rdy[2]), 32'h1);
      chk("ws3_rst_resp", 32'(rsp[2]), 32'h0);
      reset_n = 1'b1;
      addr_phase(32'h40, 1'b0, 3'd2);
      tick();
      htrans = 2'd0;
      tick();
      tick();
      tick();
      chk("ws3_rd_ready", 32'(rdy[2]), 32'h1);
      chk("ws3_rd_data", rd3, 32'hCAFEF00D);
      tick();
      chk("ws3_idle_rdata", rd3, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite slave with a byte-addressable on-chip memory, programmable wait states and a two-cycle ERROR response. It is the responder that pairs with the AHB master VIP: `hready` and `hresp` become real slave-driven outputs, and the bench runs against real RTL instead of a passive bus. It sits behind the interconnect decoder, selected by `hsel`.

## Interface
- `AHB_DW`, 32: data width in bits; one of 32 or 64.
- `AHB_AW`, 32: address width in bits.
- `MEM_DEPTH`, 1024: memory size in `AHB_DW`-wide words.
- `WAIT_STATES`, 0: number of `hreadyout`-low cycles inserted in every OKAY data phase; range 0..15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `hsel` in 1: slave select from the decoder.
- `haddr` in `AHB_AW`: byte address.
- `htrans` in 2: transfer type. IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite` in 1: 1 = write, 0 = read.
- `hsize` in 3: transfer size, 2^`hsize` bytes.
- `hburst` in 3: burst type. Accepted but not decoded; each beat stands alone.
- `hwdata` in `AHB_DW`: write data, sampled in the data phase.
- `hready` in 1: bus-level HREADY from the interconnect.
- `hreadyout` out 1: slave ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out `AHB_DW`: read data.

## Operation
- **Address-phase acceptance:** on a rising edge with `hsel & hready & htrans[1]`. The slave then registers `haddr`, `hwrite`, `hsize`, and the error flag.
- **No-op transfers:** IDLE and BUSY, or `hsel`=0 with `hready`=1, give a zero-wait OKAY. Nothing is registered.
- **Error condition**, any of:
  - word index `haddr >> log2(AHB_DW/8)` is at or above `MEM_DEPTH`;
  - `hsize > log2(AHB_DW/8)`;
  - `haddr` is not aligned to 2^`hsize`.
- **State machine**, states IDLE, DATA, ERR1, ERR2:
  - IDLE goes to DATA on an accepted OK transfer when `WAIT_STATES` > 0. When `WAIT_STATES` = 0 the transfer completes in the first data cycle: a single DATA cycle with `hreadyout`=1.
  - IDLE goes to ERR1 on an accepted erroring transfer.
  - DATA holds `hreadyout`=0 while the wait counter is below `WAIT_STATES`. It then drives `hreadyout`=1 for one cycle, which completes the transfer.
  - When a transfer completes, the next state is chosen by that edge's acceptance: DATA or ERR1 if a new transfer is accepted, otherwise IDLE.
  - ERR1 drives `hreadyout`=0 and `hresp`=1, then goes to ERR2.
  - ERR2 drives `hreadyout`=1 and `hresp`=1. Its next state follows the same acceptance rule as DATA. A master that cancels by driving IDLE lands in IDLE.
- **Write:**
  - Commits on the edge ending the completing data cycle, using the `hwdata` present in that cycle.
  - Byte lanes are little-endian and selected by `hsize` and the low address bits; the other lanes are untouched.
  - An erroring write never modifies memory.
- **Read:**
  - `hrdata` is the full word at the registered index, driven only in the completing OK read cycle; otherwise it is 0.
  - Every lane is driven; the master extracts its bytes.
- **Hazard:** a write immediately followed by a read of the same address returns the new data. This holds because the write commits before the read's data phase.
- **Wait counter:** width `$clog2(WAIT_STATES+1)`. It clears at entry to DATA and saturates at `WAIT_STATES`.

## Timing
- **Reset values:** `hreadyout`=1, `hresp`=0, `hrdata`=0, state IDLE, counter 0.
- **Memory and reset:** memory contents are not reset. Asserting `reset_n` low mid-transfer drops any pending write and returns to IDLE on that edge.
- **OK transfer latency:** data phase of `WAIT_STATES`+1 cycles.
- **ERROR latency:** always exactly 2 cycles, regardless of `WAIT_STATES`.
- **Back-to-back transfers:** zero idle cycles between them. The next address phase overlaps the completing data cycle.
- **Address sampling:** while `hready`=0 (own wait states or another slave's), address-phase inputs are ignored.
- **Input stability:** `hwdata` is sampled only in the cycle where `hreadyout`=1.

## Structure
- **Shared package `ahb_pkg`:**
  - `htrans_e` (IDLE/BUSY/NONSEQ/SEQ);
  - `hsize_e`;
  - `HRESP_OKAY`/`HRESP_ERROR` constants;
  - `ahb_slv_state_e` (IDLE/DATA/ERR1/ERR2).
- **Sub-module `ahb_sram_mem`:** `MEM_DEPTH` x `AHB_DW` array with a per-byte write enable, a write port, and a combinational read port.
- **Top level:** FSM, error decode, lane-strobe generation and output muxing.

## Test plan
1. **Reset:** hold `reset_n`=0 for 3 cycles -> `hreadyout`=1, `hresp`=0, `hrdata`=0.
2. **Zero-wait word round trip:** `WAIT_STATES`=0; write word 0xDEADBEEF to 0x10, then immediately read 0x10 -> read completes in 1 cycle and returns 0xDEADBEEF, OKAY.
3. **Halfword lanes with wait states:** `WAIT_STATES`=2; halfword write 0xA5A5 to 0x22 over word 0x12345678 -> each phase has 2 low cycles then ready; readback of 0x20 = 0xA5A55678.
4. **Out-of-range address:** NONSEQ write to byte address `MEM_DEPTH*4` -> ERR1 (`hreadyout`=0, `hresp`=1), then ERR2 (1,1); memory unchanged; a follow-up read of a valid address returns OKAY.
5. **Misaligned word:** read at 0x02 -> two-cycle ERROR; `hrdata`=0.
6. **Reset mid-transfer:** `WAIT_STATES`=3; assert `reset_n`=0 in the second wait cycle of a write to 0x40 -> next cycle IDLE with `hreadyout`=1; a later read of 0x40 returns the pre-write value.
